cmp_event_detector: RTL and testbench

CMP_EVENT_DETECTOR -- requirements
Module: cmp_event_detector

---
 rtl/cmp_event_detector.sv | 123 ++++++++++++
 tb/tb_cmp_event_detector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_event_detector.sv
// Debounced relation tracker for an upstream GT/LT/EQ comparator.
// Emits rise/fall pulses and keeps a saturating crossing count with a sticky error flag.
module cmp_event_detector #(
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 GT,
  input  logic                 LT,
  input  logic                 EQ,
  input  logic                 clear,
  output logic [1:0]           state,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] cross_count,
  output logic                 err
);

  localparam int unsigned RUN_W = 4;

  localparam logic [1:0] ST_UNKNOWN = 2'b00;
  localparam logic [1:0] ST_BELOW   = 2'b01;
  localparam logic [1:0] ST_EQUAL   = 2'b10;
  localparam logic [1:0] ST_ABOVE   = 2'b11;

  localparam logic [RUN_W-1:0]     RUN_TARGET = RUN_W'(DEBOUNCE);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  logic [1:0]           cand;
  logic [RUN_W-1:0]     run;

  logic [1:0]           state_nxt;
  logic [1:0]           cand_nxt;
  logic [RUN_W-1:0]     run_nxt;
  logic [RUN_W-1:0]     run_inc;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 err_nxt;

  logic                 one_hot;
  logic                 sample_ok;
  logic                 sample_bad;
  logic [1:0]           sample;

  // Exactly one flag set: odd parity but not all three.
  assign one_hot    = (GT ^ LT ^ EQ) & ~(GT & LT & EQ);
  assign sample_ok  = in_valid & one_hot;
  assign sample_bad = in_valid & ~one_hot;

  always_comb begin
    sample = ST_UNKNOWN;
    if (GT)      sample = ST_ABOVE;
    else if (LT) sample = ST_BELOW;
    else if (EQ) sample = ST_EQUAL;
  end

  // Next-state: debounce run, acceptance, pulses, counter and error flag.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    run_nxt   = run;
    run_inc   = run + RUN_W'(1);
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    count_nxt = cross_count;
    err_nxt   = err;

    if (sample_ok) begin
      if (sample == state) begin
        run_nxt = '0;
      end else begin
        if (sample == cand) begin
          run_nxt = run_inc;
        end else begin
          cand_nxt = sample;
          run_nxt  = RUN_W'(1);
        end
        if (run_nxt == RUN_TARGET) begin
          state_nxt = sample;
          run_nxt   = '0;
          rise_nxt  = (sample == ST_ABOVE) && ((state == ST_BELOW) || (state == ST_EQUAL));
          fall_nxt  = (sample == ST_BELOW) && ((state == ST_ABOVE) || (state == ST_EQUAL));
        end
      end
    end else if (sample_bad) begin
      err_nxt = 1'b1;
    end

    if ((rise_nxt || fall_nxt) && (cross_count != CNT_MAX)) begin
      count_nxt = cross_count + CNT_WIDTH'(1);
    end

    // Clear dominates any coincident count or error update.
    if (clear) begin
      count_nxt = '0;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_UNKNOWN;
      cand        <= ST_UNKNOWN;
      run         <= '0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      cross_count <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      run         <= run_nxt;
      rise_pulse  <= rise_nxt;
      fall_pulse  <= fall_nxt;
      cross_count <= count_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_event_detector.sv
// Scoreboard bench for cmp_event_detector (DEBOUNCE=3, CNT_WIDTH=4).
module tb_cmp_event_detector;

  localparam int unsigned DEB = 3;
  localparam int unsigned CW  = 4;

  localparam logic [1:0] UNK = 2'b00;
  localparam logic [1:0] BEL = 2'b01;
  localparam logic [1:0] EQU = 2'b10;
  localparam logic [1:0] ABV = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          gt;
  logic          lt;
  logic          eq;
  logic          clear;
  logic [1:0]    state;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] cross_count;
  logic          err;

  cmp_event_detector #(.DEBOUNCE(DEB), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .GT          (gt),
    .LT          (lt),
    .EQ          (eq),
    .clear       (clear),
    .state       (state),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .cross_count (cross_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic          r;
    logic          f;
    logic [CW-1:0] c;
    logic          e;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [1:0]    m_state;
  logic [1:0]    m_cand;
  int            m_run;
  logic          m_rise;
  logic          m_fall;
  logic [CW-1:0] m_cnt;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = UNK; m_cand = UNK; m_run = 0;
    m_rise = 0; m_fall = 0; m_cnt = '0; m_err = 0;
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_step(input logic iv, input logic g, input logic l, input logic e,
                            input logic clr);
    int ones;
    logic [1:0] s;
    ones   = int'(g) + int'(l) + int'(e);
    m_rise = 0;
    m_fall = 0;
    if (iv && ones == 1) begin
      s = g ? ABV : (l ? BEL : EQU);
      if (s == m_state) begin
        m_run = 0;
      end else begin
        if (s == m_cand) m_run = m_run + 1;
        else begin m_cand = s; m_run = 1; end
        if (m_run == int'(DEB)) begin
          m_rise  = (s == ABV) && (m_state == BEL || m_state == EQU);
          m_fall  = (s == BEL) && (m_state == ABV || m_state == EQU);
          m_state = s;
          m_run   = 0;
        end
      end
    end else if (iv) begin
      m_err = 1;
    end
    if (clr) begin
      m_cnt = '0;
      m_err = 0;
    end else if ((m_rise || m_fall) && m_cnt != 4'hF) begin
      m_cnt = m_cnt + 4'd1;
    end
  endtask

  task automatic drive(input logic iv, input logic g, input logic l, input logic e,
                       input logic clr);
    exp_t x;
    @(negedge clk);
    in_valid = iv; gt = g; lt = l; eq = e; clear = clr;
    model_step(iv, g, l, e, clr);
    sb.push_back('{st: m_state, r: m_rise, f: m_fall, c: m_cnt, e: m_err});
    @(posedge clk);
    #1;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("state", 32'(state), 32'(x.st));
      chk("rise", 32'(rise_pulse), 32'(x.r));
      chk("fall", 32'(fall_pulse), 32'(x.f));
      chk("count", 32'(cross_count), 32'(x.c));
      chk("err", 32'(err), 32'(x.e));
      chk("excl", 32'(rise_pulse & fall_pulse), 32'd0);
    end
  endtask

  task automatic smp(input logic [1:0] rel, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, rel == ABV, rel == BEL, rel == EQU, 1'b0);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    in_valid = 0; gt = 0; lt = 0; eq = 0; clear = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(UNK));
    chk("rst_rise", 32'(rise_pulse), 32'd0);
    chk("rst_fall", 32'(fall_pulse), 32'd0);
    chk("rst_count", 32'(cross_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; gt = 0; lt = 0; eq = 0; clear = 0;
    rst_n = 1'b1;
    model_reset();
    async_reset();

    // Leaving UNKNOWN: no pulse, no count.
    smp(BEL, 2);
    chk("below_early", 32'(state), 32'(UNK));
    smp(BEL, 1);
    chk("below_accept", 32'(state), 32'(BEL));
    chk("below_cnt", 32'(cross_count), 32'd0);

    smp(ABV, 3);
    chk("rise_seen", 32'(rise_pulse), 32'd1);
    chk("rise_cnt", 32'(cross_count), 32'd1);
    idle();
    chk("rise_once", 32'(rise_pulse), 32'd0);

    smp(BEL, 3);
    chk("fall_seen", 32'(fall_pulse), 32'd1);
    // Interrupted run restarts.
    smp(ABV, 2); smp(BEL, 1); smp(ABV, 2);
    chk("interrupt_hold", 32'(state), 32'(BEL));
    smp(ABV, 1);
    chk("interrupt_accept", 32'(state), 32'(ABV));

    // Gaps hold the run.
    smp(BEL, 1); idle(); idle(); smp(BEL, 1); idle(); smp(BEL, 1);
    chk("gap_accept", 32'(state), 32'(BEL));

    // Into EQUAL silently, then out of EQUAL with a rise.
    smp(EQU, 3);
    chk("equal_state", 32'(state), 32'(EQU));
    chk("equal_nopulse", 32'(rise_pulse | fall_pulse), 32'd0);
    smp(ABV, 3);
    chk("eq_rise", 32'(rise_pulse), 32'd1);

    // Bad samples and clear.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_hold", 32'(state), 32'(ABV));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_cnt", 32'(cross_count), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("bad_with_clear", 32'(err), 32'd0);

    // Event coincident with clear.
    smp(BEL, 2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_evt_pulse", 32'(fall_pulse), 32'd1);
    chk("clr_evt_cnt", 32'(cross_count), 32'd0);

    // Saturation.
    for (int i = 0; i < 10; i++) begin
      smp(ABV, 3);
      smp(BEL, 3);
    end
    chk("saturate", 32'(cross_count), 32'hF);

    // Random mix.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    // Reset mid-debounce.
    async_reset();
    smp(ABV, 2);
    async_reset();
    smp(ABV, 1);
    chk("post_reset_hold", 32'(state), 32'(UNK));
    smp(ABV, 2);
    chk("post_reset_accept", 32'(state), 32'(ABV));
    chk("post_reset_nopulse", 32'(rise_pulse), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
